ref_particle_scheduler: RTL and testbench

- Sequences one home cell's reference-particle loop for the force pipeline.
- Reads the particle count from home memory address 0, then primes reference particle 1.
- For each reference particle it runs a phase-0 pass then a phase-1 pass over the neighbour-particle stream, and prefetches the next reference from home memory during phase 1.
- Drives phase, prev_phase, reading_particle_num, ref_id and particle_id to the per-filter reference extractors. It also drives the neighbour read stream.

---
 rtl/ref_particle_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_ref_particle_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ref_particle_scheduler.sv
// Reference-particle loop sequencer for one home cell: reads the particle count,
// then runs a phase-0 and a phase-1 neighbour pass per reference, prefetching the next one.
module ref_particle_scheduler #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NB_ADDR_WIDTH     = 9,
  parameter int PHASE_GAP         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH-1:0] home_count_in,
  input  logic [NB_ADDR_WIDTH-1:0]     nb_count_p0,
  input  logic [NB_ADDR_WIDTH-1:0]     nb_count_p1,
  input  logic                         pipe_ready,
  output logic                         home_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0] home_rd_addr,
  output logic                         nb_rd_en,
  output logic [NB_ADDR_WIDTH-1:0]     nb_rd_addr,
  output logic                         reading_particle_num,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic                         phase,
  output logic                         prev_phase,
  output logic                         busy,
  output logic                         done,
  output logic                         count_err
);

  localparam int PW = PARTICLE_ID_WIDTH;
  localparam int NW = NB_ADDR_WIDTH;
  localparam int GW = (PHASE_GAP < 2) ? 1 : $clog2(PHASE_GAP + 1);
  // Largest count that still lets ref_id+1 fit without wrapping to 0.
  localparam logic [PW-1:0] CNT_MAX  = {{(PW-1){1'b1}}, 1'b0};
  localparam logic [GW-1:0] GAP_LAST = GW'(PHASE_GAP);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_NUM, S_CNT, S_PRIME, S_PHASE0, S_GAP0, S_PHASE1, S_GAP1, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ref_id_q, ref_id_d;
  logic [NW-1:0] nb_cnt_q, nb_cnt_d;
  logic [NW-1:0] iss_q, iss_d;
  logic          occ_q, occ_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          home_rd_en_q, home_rd_en_d;
  logic [PW-1:0] home_rd_addr_q, home_rd_addr_d;
  logic          nb_rd_en_q, nb_rd_en_d;
  logic [NW-1:0] nb_rd_addr_q, nb_rd_addr_d;
  logic          reading_q, reading_d;
  logic [PW-1:0] particle_id_q, particle_id_d;
  logic          phase_q, phase_d;
  logic          prev_phase_q, prev_phase_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          count_err_q, count_err_d;
  logic          enter_p0_s, enter_p1_s;

  // Next-state and next-output logic; outputs are computed for the cycle being entered.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ref_id_d       = ref_id_q;
    nb_cnt_d       = nb_cnt_q;
    iss_d          = iss_q;
    occ_d          = occ_q;
    gap_d          = gap_q;
    count_err_d    = count_err_q;
    home_rd_en_d   = 1'b0;
    home_rd_addr_d = '0;
    nb_rd_en_d     = 1'b0;
    nb_rd_addr_d   = nb_rd_addr_q;
    reading_d      = 1'b0;
    enter_p0_s     = 1'b0;
    enter_p1_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RD_NUM;
          count_err_d  = 1'b0;
          cnt_d        = '0;
          ref_id_d     = '0;
          home_rd_en_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_NUM: begin
        state_d   = S_CNT;
        reading_d = 1'b1;
      end
      S_CNT: begin
        if (home_count_in > CNT_MAX) begin
          cnt_d       = CNT_MAX;
          count_err_d = 1'b1;
        end else begin
          cnt_d = home_count_in;
        end
        if (home_count_in == '0) begin
          state_d = S_DONE;
        end else begin
          state_d        = S_PRIME;
          home_rd_en_d   = 1'b1;
          home_rd_addr_d = PW'(1);
          ref_id_d       = PW'(1);
        end
      end
      S_PRIME: enter_p0_s = 1'b1;
      S_PHASE0, S_PHASE1: begin
        // A phase ends only once every issue is out and it has lasted two cycles.
        if (iss_q == nb_cnt_q && occ_q) begin
          state_d = (state_q == S_PHASE0) ? S_GAP0 : S_GAP1;
          gap_d   = GW'(1);
        end else begin
          occ_d = 1'b1;
          if (iss_q < nb_cnt_q && pipe_ready) begin
            nb_rd_en_d   = 1'b1;
            nb_rd_addr_d = iss_q;
            iss_d        = iss_q + NW'(1);
          end else begin
            nb_rd_en_d = 1'b0;
          end
        end
      end
      S_GAP0: begin
        if (gap_q >= GAP_LAST) begin
          enter_p1_s = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_GAP1: begin
        if (gap_q < GAP_LAST) begin
          gap_d = gap_q + GW'(1);
        end else if (ref_id_q < cnt_q) begin
          ref_id_d   = ref_id_q + PW'(1);
          enter_p0_s = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_p0_s) begin
      state_d  = S_PHASE0;
      nb_cnt_d = nb_count_p0;
      occ_d    = 1'b0;
      iss_d    = '0;
      if (pipe_ready && nb_count_p0 != '0) begin
        nb_rd_en_d   = 1'b1;
        nb_rd_addr_d = '0;
        iss_d        = NW'(1);
      end else begin
        nb_rd_en_d = 1'b0;
      end
    end else if (enter_p1_s) begin
      state_d  = S_PHASE1;
      nb_cnt_d = nb_count_p1;
      occ_d    = 1'b0;
      iss_d    = '0;
      if (pipe_ready && nb_count_p1 != '0) begin
        nb_rd_en_d   = 1'b1;
        nb_rd_addr_d = '0;
        iss_d        = NW'(1);
      end else begin
        nb_rd_en_d = 1'b0;
      end
      // Prefetch of the next reference is independent of pipe_ready.
      if (ref_id_q < cnt_q) begin
        home_rd_en_d   = 1'b1;
        home_rd_addr_d = ref_id_q + PW'(1);
      end else begin
        home_rd_en_d = 1'b0;
      end
    end else begin
      iss_d = iss_d;
    end

    if (state_d == S_IDLE) begin
      nb_rd_addr_d = '0;
    end else begin
      nb_rd_addr_d = nb_rd_addr_d;
    end

    phase_d       = (state_d == S_PHASE1) || (state_d == S_GAP1);
    prev_phase_d  = phase_q;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    particle_id_d = home_rd_en_q ? home_rd_addr_q : '0;
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      ref_id_q       <= '0;
      nb_cnt_q       <= '0;
      iss_q          <= '0;
      occ_q          <= 1'b0;
      gap_q          <= '0;
      home_rd_en_q   <= 1'b0;
      home_rd_addr_q <= '0;
      nb_rd_en_q     <= 1'b0;
      nb_rd_addr_q   <= '0;
      reading_q      <= 1'b0;
      particle_id_q  <= '0;
      phase_q        <= 1'b0;
      prev_phase_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      count_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ref_id_q       <= ref_id_d;
      nb_cnt_q       <= nb_cnt_d;
      iss_q          <= iss_d;
      occ_q          <= occ_d;
      gap_q          <= gap_d;
      home_rd_en_q   <= home_rd_en_d;
      home_rd_addr_q <= home_rd_addr_d;
      nb_rd_en_q     <= nb_rd_en_d;
      nb_rd_addr_q   <= nb_rd_addr_d;
      reading_q      <= reading_d;
      particle_id_q  <= particle_id_d;
      phase_q        <= phase_d;
      prev_phase_q   <= prev_phase_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      count_err_q    <= count_err_d;
    end
  end

  assign home_rd_en           = home_rd_en_q;
  assign home_rd_addr         = home_rd_addr_q;
  assign nb_rd_en             = nb_rd_en_q;
  assign nb_rd_addr           = nb_rd_addr_q;
  assign reading_particle_num = reading_q;
  assign particle_id          = particle_id_q;
  assign ref_id               = ref_id_q;
  assign phase                = phase_q;
  assign prev_phase           = prev_phase_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign count_err            = count_err_q;

endmodule

// File: tb/tb_ref_particle_scheduler.sv
// Directed bench for ref_particle_scheduler: table of whole-cell runs with hand-computed
// totals, plus stall and mid-operation reset sequences.
module tb_ref_particle_scheduler;

  logic       clk, rst, start, pipe_ready;
  logic [6:0] home_count_in;
  logic [8:0] nb_count_p0, nb_count_p1;
  logic       home_rd_en, nb_rd_en, reading_particle_num, phase, prev_phase, busy, done, count_err;
  logic [6:0] home_rd_addr, particle_id, ref_id;
  logic [8:0] nb_rd_addr;

  ref_particle_scheduler #(.PARTICLE_ID_WIDTH(7), .NB_ADDR_WIDTH(9), .PHASE_GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .home_count_in(home_count_in),
    .nb_count_p0(nb_count_p0), .nb_count_p1(nb_count_p1), .pipe_ready(pipe_ready),
    .home_rd_en(home_rd_en), .home_rd_addr(home_rd_addr), .nb_rd_en(nb_rd_en),
    .nb_rd_addr(nb_rd_addr), .reading_particle_num(reading_particle_num),
    .particle_id(particle_id), .ref_id(ref_id), .phase(phase), .prev_phase(prev_phase),
    .busy(busy), .done(done), .count_err(count_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt; int p0; int p1;
    int done_cyc; int issues; int reads; int ref_max; int falls; int err;
  } vec_t;

  vec_t vecs[7];
  int n_checks = 0;
  int n_fail   = 0;
  int s_done, s_issues, s_reads, s_ref_max, s_falls, s_err, s_proto, s_addr;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint all_outs();
    return {home_rd_en, home_rd_addr, nb_rd_en, nb_rd_addr, reading_particle_num,
            particle_id, ref_id, phase, prev_phase, busy, done, count_err};
  endfunction

  // Called right after a negedge; the following negedge shows cycle 1.
  task automatic launch(input int cnt, input int c0, input int c1);
    home_count_in = 7'(cnt);
    nb_count_p0   = 9'(c0);
    nb_count_p1   = 9'(c1);
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  // Protocol observer for one cell run; samples once per negedge until done or budget.
  task automatic monitor(input int p0, input int p1, input int stall_at, input int stall_len,
                         input int budget);
    int         exp_k;
    logic       last_en, last_ph;
    logic [6:0] last_addr, last_ref;
    exp_k = 0; last_en = 1'b0; last_ph = 1'b0; last_addr = 7'd0; last_ref = 7'd0;
    s_done = -1; s_issues = 0; s_reads = 0; s_ref_max = 0; s_falls = 0;
    s_err = -1; s_proto = 0; s_addr = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (home_rd_en) s_reads++;
      if (home_rd_en && reading_particle_num) s_proto++;
      if (particle_id != (last_en ? last_addr : 7'd0)) s_proto++;
      if (particle_id == 7'h7f) s_proto++;
      if (cyc == 1 && !(home_rd_en && home_rd_addr == 7'd0 && busy)) s_proto++;
      if (cyc == 2 && !reading_particle_num) s_proto++;
      if (cyc > 3 && home_rd_en && !(phase && !prev_phase && home_rd_addr == ref_id + 7'd1))
        s_proto++;
      if (last_en && last_ph && !(phase && prev_phase && particle_id == ref_id + 7'd1))
        s_proto++;
      if (ref_id != last_ref) begin
        if (last_ref == 7'd0) begin
          if (ref_id != 7'd1) s_proto++;
        end else if (!(ref_id == last_ref + 7'd1 && !phase && prev_phase)) begin
          s_proto++;
        end
      end
      if (int'(ref_id) > s_ref_max) s_ref_max = int'(ref_id);
      if (prev_phase && !phase) s_falls++;
      if (phase != prev_phase) begin
        if (phase && exp_k != p0) s_addr++;
        if (!phase && exp_k != p1) s_addr++;
        exp_k = 0;
      end
      if (nb_rd_en) begin
        s_issues++;
        if (int'(nb_rd_addr) != exp_k) s_addr++;
        exp_k++;
      end
      if (stall_len > 0 && cyc > stall_at && cyc <= stall_at + stall_len &&
          (nb_rd_en || int'(nb_rd_addr) != exp_k - 1)) s_addr++;
      if (nb_rd_en && !busy) s_proto++;
      last_en = home_rd_en; last_addr = home_rd_addr; last_ph = phase; last_ref = ref_id;
      if (done) begin
        s_done = cyc;
        s_err  = int'(count_err);
        break;
      end
      pipe_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
    end
    pipe_ready = 1'b1;
  endtask

  task automatic check_run(input string tag, input vec_t v);
    check({tag, ".done_cycle"}, s_done, v.done_cyc);
    check({tag, ".nb_issues"}, s_issues, v.issues);
    check({tag, ".home_reads"}, s_reads, v.reads);
    check({tag, ".ref_id_max"}, s_ref_max, v.ref_max);
    check({tag, ".swap_edges"}, s_falls, v.falls);
    check({tag, ".count_err"}, s_err, v.err);
    check({tag, ".protocol_errs"}, s_proto, 0);
    check({tag, ".nb_addr_errs"}, s_addr, 0);
  endtask

  initial begin
    int   found;
    int   bad;
    vec_t v;
    // cnt, p0, p1, done cycle, nb issues, home reads, max ref, 1->0 swaps, count_err
    vecs[0] = '{0,   0, 0, 3,    0,  1,   0,   0,   0};
    vecs[1] = '{1,   3, 4, 15,   7,  2,   1,   1,   0};
    vecs[2] = '{3,   2, 2, 28,   12, 4,   3,   3,   0};
    vecs[3] = '{2,   0, 1, 20,   2,  3,   2,   2,   0};
    vecs[4] = '{2,   5, 0, 26,   10, 3,   2,   2,   0};
    vecs[5] = '{127, 0, 0, 1012, 0,  127, 126, 126, 1};
    vecs[6] = '{1,   1, 1, 12,   2,  2,   1,   1,   0};

    rst = 1'b1; start = 1'b0; pipe_ready = 1'b1;
    home_count_in = 7'd0; nb_count_p0 = 9'd0; nb_count_p1 = 9'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].cnt, vecs[i].p0, vecs[i].p1);
      monitor(vecs[i].p0, vecs[i].p1, 0, 0, 2000);
      check_run($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d.done_pulse", i), {done, busy}, 0);
    end

    // Five-cycle stall in phase 0: issue stops, address holds, run stretches by five.
    launch(1, 6, 2);
    monitor(6, 2, 5, 5, 2000);
    v = '{1, 6, 2, 21, 8, 2, 1, 1, 0};
    check_run("stall", v);
    @(negedge clk);

    // Reset during phase 1 of reference 2, then restart.
    launch(3, 2, 2);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (ref_id == 7'd2 && phase) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst.reached_ref2_phase1", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst.outputs_zero", all_outs(), 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("rst.no_done_stays_idle", bad, 0);
    launch(1, 1, 1);
    monitor(1, 1, 0, 0, 2000);
    check_run("restart", vecs[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
